// File: rtl/bm_dag3_stim_chk_pkg.sv
// Shared types and constants for the DAG3 stimulus/checker block.
// Holds the FSM encoding, default geometry and the saturating counter helper.
package bm_dag3_stim_chk_pkg;

  localparam int DEF_BITS = 2;
  localparam int DEF_LAT  = 1;
  localparam int ERR_W    = 8;
  localparam int DRAIN_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/bm_dag3_stim_chk_model.sv
// Golden combinational model of the DAG3 function, evaluated exactly as the
// DAG computes it; shared by the checker and by benches.
module bm_dag3_model #(
  parameter int BITS = 2
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] exp
);

  logic [BITS-1:0] c_s;
  logic [BITS-1:0] p_s;
  logic [BITS-1:0] q_s;
  logic [BITS-1:0] d_s;

  // Full expression kept even though q is always all-ones.
  always_comb begin
    c_s = ~a;
    p_s = b & c_s;
    q_s = a ^ c_s;
    d_s = q_s | b;
    exp = p_s | q_s | c_s | d_s;
  end

endmodule

// File: rtl/bm_dag3_stim_chk.sv
// Sweeps every a/b operand pair into the DAG, compares the result LAT cycles
// later against bm_dag3_model and reports mismatch count, first failure and pass.
module bm_dag3_stim_chk
  import bm_dag3_stim_chk_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int LAT  = DEF_LAT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic [BITS-1:0]      a_out,
  output logic [BITS-1:0]      b_out,
  input  logic [BITS-1:0]      dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*BITS-1:0]    first_err_idx
);

  localparam int IW = 2 * BITS;
  localparam logic [IW-1:0]      IDX_LAST   = {IW{1'b1}};
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((LAT > 0) ? (LAT - 1) : 0);

  state_t               state_r;
  state_t               state_nx_s;
  logic [IW-1:0]        idx_r;
  logic [IW-1:0]        idx_nx_s;
  logic [DRAIN_W-1:0]   drain_r;
  logic [DRAIN_W-1:0]   drain_nx_s;
  logic                 run_enter_s;

  logic                 vld0_s;
  logic [BITS-1:0]      exp0_s;
  logic                 cmp_vld_s;
  logic [BITS-1:0]      cmp_exp_s;
  logic [IW-1:0]        cmp_idx_s;

  logic                 mism_s;
  logic                 first_seen_r;
  logic                 first_seen_nx_s;
  logic [ERR_W-1:0]     err_nx_s;
  logic [IW-1:0]        fei_nx_s;

  // Next-state logic; idx_r always names the vector currently on a_out/b_out.
  always_comb begin
    state_nx_s  = state_r;
    idx_nx_s    = idx_r;
    drain_nx_s  = drain_r;
    run_enter_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx_s  = ST_RUN;
          idx_nx_s    = {IW{1'b0}};
          run_enter_s = 1'b1;
        end else begin
          state_nx_s  = state_r;
        end
      end
      ST_RUN: begin
        if (idx_r == IDX_LAST) begin
          idx_nx_s   = {IW{1'b0}};
          drain_nx_s = DRAIN_LAST;
          state_nx_s = (LAT > 0) ? ST_DRAIN : ST_DONE;
        end else begin
          idx_nx_s   = idx_r + IW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_r == {DRAIN_W{1'b0}}) begin
          state_nx_s = ST_DONE;
        end else begin
          drain_nx_s = drain_r - DRAIN_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign vld0_s = (state_r == ST_RUN);

  bm_dag3_model #(.BITS(BITS)) u_model (
    .a   (a_out),
    .b   (b_out),
    .exp (exp0_s)
  );

  // Expected value, valid and index ride a LAT-deep line to meet the DAG result.
  generate
    if (LAT == 0) begin : g_lat0
      always_comb begin
        cmp_vld_s = vld0_s;
        cmp_exp_s = exp0_s;
        cmp_idx_s = idx_r;
      end
    end else begin : g_latn
      logic [LAT-1:0]  vld_dl_r;
      logic [BITS-1:0] exp_dl_r [LAT];
      logic [IW-1:0]   idx_dl_r [LAT];

      // Delay line; reset drops every in-flight compare.
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int i = 0; i < LAT; i++) begin
            vld_dl_r[i] <= 1'b0;
            exp_dl_r[i] <= {BITS{1'b0}};
            idx_dl_r[i] <= {IW{1'b0}};
          end
        end else begin
          vld_dl_r[0] <= vld0_s;
          exp_dl_r[0] <= exp0_s;
          idx_dl_r[0] <= idx_r;
          for (int i = 1; i < LAT; i++) begin
            vld_dl_r[i] <= vld_dl_r[i-1];
            exp_dl_r[i] <= exp_dl_r[i-1];
            idx_dl_r[i] <= idx_dl_r[i-1];
          end
        end
      end

      // Tap the oldest stage for comparison.
      always_comb begin
        cmp_vld_s = vld_dl_r[LAT-1];
        cmp_exp_s = exp_dl_r[LAT-1];
        cmp_idx_s = idx_dl_r[LAT-1];
      end
    end
  endgenerate

  // Checker update; a fresh sweep clears results before any compare can land.
  always_comb begin
    mism_s          = cmp_vld_s && (dut_out != cmp_exp_s);
    err_nx_s        = err_count;
    fei_nx_s        = first_err_idx;
    first_seen_nx_s = first_seen_r;
    if (run_enter_s) begin
      err_nx_s        = {ERR_W{1'b0}};
      fei_nx_s        = {IW{1'b0}};
      first_seen_nx_s = 1'b0;
    end else if (mism_s) begin
      err_nx_s = sat_inc(err_count);
      if (!first_seen_r) begin
        fei_nx_s        = cmp_idx_s;
        first_seen_nx_s = 1'b1;
      end else begin
        fei_nx_s        = first_err_idx;
      end
    end else begin
      err_nx_s = err_count;
    end
  end

  // State and registered outputs, all derived from next-state values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      idx_r         <= {IW{1'b0}};
      drain_r       <= {DRAIN_W{1'b0}};
      first_seen_r  <= 1'b0;
      a_out         <= {BITS{1'b0}};
      b_out         <= {BITS{1'b0}};
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= {ERR_W{1'b0}};
      first_err_idx <= {IW{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      idx_r         <= idx_nx_s;
      drain_r       <= drain_nx_s;
      first_seen_r  <= first_seen_nx_s;
      a_out         <= (state_nx_s == ST_RUN) ? idx_nx_s[BITS-1:0]  : {BITS{1'b0}};
      b_out         <= (state_nx_s == ST_RUN) ? idx_nx_s[IW-1:BITS] : {BITS{1'b0}};
      busy          <= (state_nx_s == ST_RUN) || (state_nx_s == ST_DRAIN);
      done          <= (state_nx_s == ST_DONE);
      pass          <= (state_nx_s == ST_DONE) && (err_nx_s == {ERR_W{1'b0}});
      err_count     <= err_nx_s;
      first_err_idx <= fei_nx_s;
    end
  end

endmodule

// File: doc/bm_dag3_stim_chk.md
# bm_dag3_stim_chk

Self-checking stimulus source and response checker for the small logic-DAG micro benchmarks. It sits on the opposite side of the DAG's operand/result interface. It drives every `a`/`b` operand pair in sequence and samples the DAG result a fixed number of cycles later. Each sample is compared against an internal model of the DAG3 function, and the block reports mismatch count, first failing vector and pass/fail.

## Interface
Parameters:
- `BITS`, 2: operand/result width; sweep length N = 2^(2·BITS).
- `LAT`, 1: cycles from operand drive to result sample; legal range 0..4.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  pulse; starts a sweep from IDLE or DONE, ignored otherwise.
- `a_out`  out  BITS  operand A to DAG (`a_in` side).
- `b_out`  out  BITS  operand B to DAG (`b_in` side).
- `dut_out`  in  BITS  DAG result.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; sticky until next start or reset.
- `pass`  out  1  `done` and `err_count == 0`.
- `err_count`  out  8  mismatch count, saturating at 255.
- `first_err_idx`  out  2·BITS  sweep index of first mismatch; 0 if none.

## Operation
- Sweep index `idx` runs 0..N-1; `a_out = idx[BITS-1:0]`, `b_out = idx[2·BITS-1:BITS]`; both registered.
- Expected model per vector, evaluated as written, bitwise:
  - c = ~a
  - p = b & c
  - q = a ^ c
  - d = q | b
  - exp = p | q | c | d
- q is all-ones, so exp is all-ones for every vector. The RTL still implements the full expression.
- Pipeline: `exp` and a valid bit travel through a LAT-deep shift register alongside `idx`. With LAT=0 the compare is same-cycle against `dut_out`.
- Compare happens only when the delayed valid bit is high. On mismatch, `err_count` increments, saturating at 255.
- On the first mismatch of a sweep, `first_err_idx` latches the delayed `idx`.
- FSM states:
  - IDLE: `start` → RUN.
  - RUN: drives one vector per cycle. After vector N-1 → DRAIN if LAT>0, else DONE.
  - DRAIN: lasts exactly LAT cycles, then → DONE.
  - DONE: `start` → RUN.
- Entering RUN clears `err_count`, `first_err_idx` and the first-error flag.
- `start` is ignored in RUN and DRAIN.
- `a_out` and `b_out` are 0 in IDLE, DRAIN and DONE.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_idx`=0. State is IDLE and the valid pipeline is cleared.
- Reset mid-sweep takes effect at the next edge. In-flight compares are discarded.

## Timing
- `start` is sampled high at edge ending cycle t. Then:
  - cycle t+1: state is RUN, `busy`=1 and vector 0 is on `a_out`/`b_out`.
  - cycle t+1+k: vector k is on the outputs.
- `dut_out` for vector k is compared at the edge ending cycle t+1+k+LAT. Counters reflect that compare from the following cycle.
- `done` rises in cycle t+N+LAT+1, and `busy` falls in the same cycle.
- For BITS=2, LAT=1: vectors occupy t+1..t+16, DRAIN is t+17, and `done` is high from t+18.
- `start` asserted in the same cycle as `reset`: reset wins.
- Restart from DONE: `done` and `pass` drop in cycle t+1.

## Structure
- Shared include file holds:
  - default `BITS`/`LAT` defines;
  - FSM state encodings (IDLE=0, RUN=1, DRAIN=2, DONE=3);
  - `err_count` width (8).
- One combinational sub-module, `bm_dag3_model`: inputs `a`, `b` (BITS), output `exp` (BITS). The same sub-module is reused by benches as the golden model.
- The top level contains the FSM, index counter, LAT delay line and checker.

## Test plan
- BITS=2, LAT=1, `dut_out` driven by `bm_dag3_model`, `start` at t → `done` from t+18, `pass`=1, `err_count`=0, `first_err_idx`=0.
- `dut_out` tied to 2'b00 → `err_count`=16, `first_err_idx`=0, `pass`=0.
- `dut_out` = 2'b11 except 2'b10 when `a_out`=2'b01 and `b_out`=2'b10 (idx 9, sampled with LAT alignment) → `err_count`=1, `first_err_idx`=9.
- `start` pulsed again at t+5 → ignored; `done` still at t+18. Separate run: `reset` at t+5 → from t+6 all outputs 0 and `busy`=0; a subsequent start completes normally.
- BITS=4, LAT=0, `dut_out`=0 → 256 vectors, `done` at t+257, `err_count` saturates at 255.
- After a failing sweep, `start` in DONE with a correct DUT → `err_count` is 0 from t+1, ends with `pass`=1.
